// File: rtl/audio_pkg.sv
// audio_pkg: shared types and widths for the tone channel.
//   env_state_t : envelope FSM states
//   RAMP_W      : wave-table phase index width
//   SAMPLE_W    : signed sample width
//   ENV_W       : envelope level width (0..15)
package audio_pkg;

    localparam int unsigned RAMP_W   = 6;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned ENV_W    = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ATTACK  = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } env_state_t;

endpackage

// File: rtl/audio_env_gen.sv
// audio_env_gen: attack/sustain/release envelope with a tick step counter.
//   clk, reset      : clock, async active-high reset
//   tick_i          : sample-rate strobe
//   key_on_i        : note start / retrigger pulse
//   key_off_i       : note release pulse (wins over key_on_i)
//   vol_i           : sustain level
//   env_o           : current envelope level (registered)
//   state_o         : current envelope state (registered)
//   busy_o          : state is not IDLE (registered with the state)
module audio_env_gen
    import audio_pkg::*;
#(
    parameter int unsigned ATTACK_TICKS  = 4,
    parameter int unsigned RELEASE_TICKS = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick_i,
    input  logic             key_on_i,
    input  logic             key_off_i,
    input  logic [ENV_W-1:0] vol_i,
    output logic [ENV_W-1:0] env_o,
    output env_state_t       state_o,
    output logic             busy_o
);

    localparam int unsigned MAX_TICKS = (ATTACK_TICKS > RELEASE_TICKS) ? ATTACK_TICKS : RELEASE_TICKS;
    localparam int unsigned CNT_W     = $clog2(MAX_TICKS + 1);

    env_state_t       state_q, state_d;
    logic [ENV_W-1:0] env_q, env_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [ENV_W-1:0] env_inc;
    logic [ENV_W-1:0] env_dec;

    assign cnt_inc = cnt_q + CNT_W'(1);
    assign env_inc = env_q + ENV_W'(1);
    assign env_dec = env_q - ENV_W'(1);

    // Next-state: key_off beats key_on; key events pre-empt that cycle's tick step.
    always_comb begin
        state_d = state_q;
        env_d   = env_q;
        cnt_d   = cnt_q;
        if (key_off_i && (state_q == ATTACK || state_q == SUSTAIN)) begin
            state_d = RELEASE;
            cnt_d   = '0;
        end else if (key_on_i && !key_off_i) begin
            state_d = ATTACK;
            cnt_d   = '0;
        end else if (tick_i) begin
            case (state_q)
                ATTACK: begin
                    if (env_q >= vol_i) begin
                        // already at or above target (e.g. retrigger from a loud note)
                        state_d = SUSTAIN;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(ATTACK_TICKS)) begin
                        cnt_d = '0;
                        env_d = env_inc;
                        if (env_inc >= vol_i) begin
                            state_d = SUSTAIN;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                SUSTAIN: begin
                    env_d = vol_i;
                end
                RELEASE: begin
                    if (env_q == '0) begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end else if (cnt_inc == CNT_W'(RELEASE_TICKS)) begin
                        cnt_d = '0;
                        env_d = env_dec;
                        if (env_dec == '0) begin
                            state_d = IDLE;
                        end
                    end else begin
                        cnt_d = cnt_inc;
                    end
                end
                default: begin
                end
            endcase
        end
        busy_d = (state_d != IDLE);
    end

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            env_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            env_q   <= env_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign env_o   = env_q;
    assign state_o = state_q;
    assign busy_o  = busy_q;

endmodule

// File: rtl/audio_tone_chan.sv
// audio_tone_chan: one tone voice - phase accumulator, envelope, volume scaling.
//   clk, reset    : clock, async active-high reset
//   tick_i        : sample-rate strobe
//   key_on_i      : note start / retrigger pulse
//   key_off_i     : note release pulse
//   freq_i        : phase increment per tick
//   vol_i         : sustain level
//   ramp_o        : phase index to the wave table (registered)
//   wave_i        : signed wave-table sample for ramp_o (same cycle)
//   sample_o      : envelope-scaled sample (registered)
//   sample_vld_o  : one-cycle pulse, sample_o updated (2 clk after tick)
//   busy_o        : envelope not IDLE
// Build option: define AUDIO_TONE_PHASE_RST_EN to restart the phase at 0 on every key_on.
module audio_tone_chan
    import audio_pkg::*;
#(
    parameter int unsigned ACC_W         = 22,
    parameter int unsigned FREQ_W        = 16,
    parameter int unsigned ATTACK_TICKS  = 4,
    parameter int unsigned RELEASE_TICKS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick_i,
    input  logic                key_on_i,
    input  logic                key_off_i,
    input  logic [FREQ_W-1:0]   freq_i,
    input  logic [3:0]          vol_i,
    output logic [RAMP_W-1:0]   ramp_o,
    input  logic [SAMPLE_W-1:0] wave_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                sample_vld_o,
    output logic                busy_o
);

    localparam int unsigned PROD_W = SAMPLE_W + ENV_W + 1;

    logic [ENV_W-1:0]           env;
    env_state_t                 state;
    logic                       busy;

    logic [ACC_W-1:0]           acc_q, acc_d;
    logic [RAMP_W-1:0]          ramp_q, ramp_d;
    logic                       pend_q, pend_d;
    logic [SAMPLE_W-1:0]        sample_q, sample_d;
    logic                       vld_q, vld_d;

    logic signed [SAMPLE_W-1:0] wave_s;
    logic signed [ENV_W:0]      env_s;
    logic signed [PROD_W-1:0]   prod_c;

    audio_env_gen #(
        .ATTACK_TICKS  (ATTACK_TICKS),
        .RELEASE_TICKS (RELEASE_TICKS)
    ) u_env (
        .clk       (clk),
        .reset     (reset),
        .tick_i    (tick_i),
        .key_on_i  (key_on_i),
        .key_off_i (key_off_i),
        .vol_i     (vol_i),
        .env_o     (env),
        .state_o   (state),
        .busy_o    (busy)
    );

    // Volume scaling: env is a 0..15 level over a full scale of 16.
    assign wave_s = wave_i;
    assign env_s  = {1'b0, env};
    assign prod_c = PROD_W'(wave_s) * PROD_W'(env_s);

    // Phase and sample pipeline. ramp_o captures the phase reached before this
    // tick's step, so a note (or a phase-reset retrigger) starts at ramp 0.
    always_comb begin
        acc_d  = acc_q;
        ramp_d = ramp_q;
        if (state == IDLE) begin
            acc_d  = '0;
            ramp_d = '0;
        end else begin
            if (tick_i) begin
                ramp_d = acc_q[ACC_W-1 -: RAMP_W];
            end
`ifdef AUDIO_TONE_PHASE_RST_EN
            if (key_on_i && !key_off_i) begin
                acc_d = '0;
            end else if (tick_i) begin
                acc_d = acc_q + ACC_W'(freq_i);
            end
`else
            if (tick_i) begin
                acc_d = acc_q + ACC_W'(freq_i);
            end
`endif
        end

        pend_d   = tick_i;
        vld_d    = pend_q;
        sample_d = sample_q;
        if (pend_q) begin
            sample_d = SAMPLE_W'(prod_c >>> ENV_W);
        end
    end

    // Pipeline registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q    <= '0;
            ramp_q   <= '0;
            pend_q   <= 1'b0;
            sample_q <= '0;
            vld_q    <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            ramp_q   <= ramp_d;
            pend_q   <= pend_d;
            sample_q <= sample_d;
            vld_q    <= vld_d;
        end
    end

    assign ramp_o       = ramp_q;
    assign sample_o     = sample_q;
    assign sample_vld_o = vld_q;
    assign busy_o       = busy;

endmodule

// File: tb/tb_audio_tone_chan.sv
// tb_audio_tone_chan: scoreboard bench for audio_tone_chan against a note-level model.
module tb_audio_tone_chan;

    localparam int ACC_W  = 22;
    localparam int FREQ_W = 17;
    localparam int AT     = 4;
    localparam int RT     = 8;
    localparam int S_IDLE = 0;
    localparam int S_ATT  = 1;
    localparam int S_SUS  = 2;
    localparam int S_REL  = 3;
`ifdef AUDIO_TONE_PHASE_RST_EN
    localparam bit PH_RST = 1'b1;
`else
    localparam bit PH_RST = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              tick_i = 1'b0;
    logic              key_on_i = 1'b0;
    logic              key_off_i = 1'b0;
    logic [FREQ_W-1:0] freq_i = '0;
    logic [3:0]        vol_i = '0;
    logic [5:0]        ramp_o;
    logic [15:0]       wave_i;
    logic [15:0]       sample_o;
    logic              sample_vld_o;
    logic              busy_o;

    logic [15:0]       wtab [64];
    assign wave_i = wtab[ramp_o];

    always #5 clk = ~clk;

    audio_tone_chan #(
        .ACC_W(ACC_W), .FREQ_W(FREQ_W), .ATTACK_TICKS(AT), .RELEASE_TICKS(RT)
    ) dut (
        .clk(clk), .reset(reset), .tick_i(tick_i), .key_on_i(key_on_i),
        .key_off_i(key_off_i), .freq_i(freq_i), .vol_i(vol_i), .ramp_o(ramp_o),
        .wave_i(wave_i), .sample_o(sample_o), .sample_vld_o(sample_vld_o), .busy_o(busy_o)
    );

    int n_checks = 0;
    int n_errs   = 0;

    // note-level model
    int m_st, m_env, m_base, m_t, m_acc, m_last_ramp;
    bit exp_busy = 1'b0;
    int ramp_q[$];
    int samp_q[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_st = S_IDLE; m_env = 0; m_base = 0; m_t = 0; m_acc = 0; m_last_ramp = 0;
        exp_busy = 1'b0;
        ramp_q.delete();
        samp_q.delete();
    endtask

    // Apply one clock of inputs to the model; queue the tick's expected ramp and sample.
    task automatic model_step(input bit tk, input bit kon, input bit koff);
        int st0;
        int nramp;
        int prod;
        bit kon_eff;
        st0     = m_st;
        kon_eff = kon && !koff;
        nramp   = 0;
        if (st0 == S_IDLE) begin
            m_acc = 0;
        end else begin
            nramp = m_acc >> (ACC_W - 6);
            if (PH_RST && kon_eff) m_acc = 0;
            else if (tk) m_acc = (m_acc + int'(freq_i)) & ((1 << ACC_W) - 1);
        end

        if (koff && (st0 == S_ATT || st0 == S_SUS)) begin
            m_st = S_REL; m_base = m_env; m_t = 0;
        end else if (kon_eff) begin
            m_st = S_ATT; m_base = m_env; m_t = 0;
        end else if (tk) begin
            if (st0 == S_ATT) begin
                if (m_env >= int'(vol_i)) m_st = S_SUS;
                else begin
                    m_t++;
                    m_env = m_base + m_t / AT;
                    if (m_env >= int'(vol_i)) m_st = S_SUS;
                end
            end else if (st0 == S_SUS) begin
                m_env = int'(vol_i);
            end else if (st0 == S_REL) begin
                if (m_env == 0) m_st = S_IDLE;
                else begin
                    m_t++;
                    m_env = m_base - m_t / RT;
                    if (m_env == 0) m_st = S_IDLE;
                end
            end
        end

        if (tk) begin
            m_last_ramp = nramp;
            ramp_q.push_back(nramp);
            prod = int'($signed(wtab[6'(nramp)])) * m_env;
            samp_q.push_back((prod >>> 4) & 32'h0000FFFF);
        end
        exp_busy = (m_st != S_IDLE);
    endtask

    task automatic cyc(input bit tk, input bit kon, input bit koff);
        tick_i = tk; key_on_i = kon; key_off_i = koff;
        model_step(tk, kon, koff);
        @(posedge clk); #3;
        tick_i = 1'b0; key_on_i = 1'b0; key_off_i = 1'b0;
    endtask

    task automatic run_to_ramp(input int r);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (m_last_ramp == r) found = 1'b1;
        end
        if (!found) begin
            n_checks++; n_errs++;
            $display("FAIL run_to_ramp: ramp %0d not reached within 200 ticks", r);
        end
    endtask

    // Monitor: ramp one clk after each tick, vld/sample two clk after, busy every clk.
    initial begin
        bit tick_hist;
        int e;
        tick_hist = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (reset) begin
                tick_hist = 1'b0;
                continue;
            end
            if (tick_i) begin
                if (ramp_q.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL ramp: no expected entry at %0t", $time);
                end else begin
                    e = ramp_q.pop_front();
                    chk("ramp", 32'(ramp_o), e);
                end
            end
            chk("vld", 32'(sample_vld_o), 32'(tick_hist));
            if (sample_vld_o) begin
                if (samp_q.size() == 0) begin
                    n_checks++; n_errs++;
                    $display("FAIL sample: unexpected vld got %0h at %0t", sample_o, $time);
                end else begin
                    e = samp_q.pop_front();
                    chk("sample", 32'(sample_o), e);
                end
            end
            chk("busy", 32'(busy_o), 32'(exp_busy));
            tick_hist = tick_i;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 64; i++) wtab[i] = (i < 32) ? 16'hE000 : 16'h1FFF;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        #3;
        chk("rst_ramp", 32'(ramp_o), 0);
        chk("rst_sample", 32'(sample_o), 0);
        chk("rst_vld", 32'(sample_vld_o), 0);
        chk("rst_busy", 32'(busy_o), 0);
        reset = 1'b0;
        #1;

        // idle ticks, including back-to-back
        for (int i = 0; i < 12; i++) cyc(i % 3 != 0, 1'b0, 1'b0);
        chk("idle_ramp", 32'(ramp_o), 0);
        chk("idle_sample", 32'(sample_o), 0);
        chk("idle_busy", 32'(busy_o), 0);

        // square table, full volume
        freq_i = 17'h10000;
        vol_i  = 4'd15;
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 70; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("sq_busy", 32'(busy_o), 1);
        run_to_ramp(40);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sq_high", 32'(sample_o), 32'h1DFF);
        run_to_ramp(5);
        cyc(1'b0, 1'b0, 1'b0);
        chk("sq_low", 32'(sample_o), 32'hE200);

        // release from 15 takes 15*8 ticks
        cyc(1'b0, 1'b0, 1'b1);
        for (int i = 1; i <= 120; i++) begin
            cyc(1'b1, 1'b0, 1'b0);
            if (i == 119) chk("rel_busy_119", 32'(busy_o), 1);
            cyc(1'b0, 1'b0, 1'b0);
        end
        chk("rel_busy_120", 32'(busy_o), 0);
        cyc(1'b0, 1'b0, 1'b0);
        chk("rel_ramp0", 32'(ramp_o), 0);

        // vol 4: sustain after 16 ticks
        vol_i = 4'd4;
        cyc(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("vol4_busy", 32'(busy_o), 1);
        cyc(1'b0, 1'b0, 1'b0);
        chk("vol4_low", 32'(sample_o), 32'hF800);

        // retrigger at ramp 20
        run_to_ramp(20);
        cyc(1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        chk("retrig_ramp", 32'(ramp_o), PH_RST ? 0 : 21);

        // key_on with key_off in sustain: release, no retrigger
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0, 1'b0);
        chk("both_busy", 32'(busy_o), 1);

        // reset during release
        reset = 1'b1;
        #1;
        chk("midrst_ramp", 32'(ramp_o), 0);
        chk("midrst_sample", 32'(sample_o), 0);
        chk("midrst_vld", 32'(sample_vld_o), 0);
        chk("midrst_busy", 32'(busy_o), 0);
        model_reset();
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);

        // random wave table and traffic
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 64; i++) wtab[i] = 16'($urandom);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 99) == 0) freq_i = FREQ_W'($urandom);
            if ($urandom_range(0, 199) == 0) vol_i = 4'($urandom);
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 149) == 0, $urandom_range(0, 49) == 0);
        end

        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0);
        chk("drain_ramp", 32'(ramp_q.size()), 0);
        chk("drain_sample", 32'(samp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule

// File: doc/audio_tone_chan.md
Name: audio_tone_chan

Overview:
- Single tone channel that drives the 6-bit phase (ramp) input of a combinational wave table and consumes its 16-bit signed sample output.
- Contains a phase accumulator stepped on the audio sample tick, an ADSR-lite envelope FSM (attack/sustain/release) and a registered volume-scaling stage.
- Sits between the sound-register interface and the channel mixer; one instance per voice.

Parameters:
- ACC_W, 22, phase accumulator width; ramp_o = acc[ACC_W-1 -: 6].
- FREQ_W, 16, phase increment width (zero-extended to ACC_W).
- ATTACK_TICKS, 4, sample ticks per +1 envelope step in ATTACK (>=1).
- RELEASE_TICKS, 8, sample ticks per -1 envelope step in RELEASE (>=1).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- tick_i  in  1  sample-rate strobe, one clk wide
- key_on_i  in  1  note start/retrigger pulse
- key_off_i  in  1  note release pulse
- freq_i  in  FREQ_W  phase increment per tick
- vol_i  in  4  target (sustain) level, 0..15
- ramp_o  out  6  phase index to wave table
- wave_i  in  16  signed sample from wave table, same-cycle response to ramp_o
- sample_o  out  16  signed scaled sample
- sample_vld_o  out  1  one-cycle pulse, sample_o updated
- busy_o  out  1  high when FSM is not IDLE

Behaviour:
- Clocking: one clock, clk. Reset is asynchronous and active-high on reset.
- Reset values: acc=0, ramp_o=0, env=0, state=IDLE, sample_o=0, sample_vld_o=0, busy_o=0, step counter=0.
- Reset mid-note: all state returns to reset values immediately; no further sample_vld_o pulses until a tick occurs after reset deasserts.
- FSM states: IDLE, ATTACK, SUSTAIN, RELEASE.
  - IDLE -> ATTACK on key_on_i.
  - ATTACK: every ATTACK_TICKS ticks, env += 1. Move to SUSTAIN when env >= vol_i. If vol_i <= env on entry, move to SUSTAIN on the next tick.
  - SUSTAIN: env = vol_i every tick, so volume changes track.
  - ATTACK/SUSTAIN -> RELEASE on key_off_i.
  - RELEASE: every RELEASE_TICKS ticks, env -= 1. At env==0, go to IDLE and clear acc.
  - key_on_i in ATTACK/SUSTAIN/RELEASE retriggers: state=ATTACK, env continues from its current value, step counter cleared.
  - key_on_i and key_off_i in the same cycle: key_off_i wins. From IDLE this is a no-op.
  - key_off_i in IDLE is ignored.
- Phase:
  - On tick_i in a non-IDLE state, acc <= acc + freq_i, modulo 2^ACC_W (wraps silently).
  - ramp_o is a register, updated the cycle after tick.
  - In IDLE, acc holds 0.
- Pipeline:
  - tick at cycle T -> ramp_o new at T+1.
  - wave_i is sampled at T+1.
  - sample_o and sample_vld_o are valid at T+2. Latency 2 clk.
  - sample_vld_o pulses on every tick, including in IDLE, where sample_o=0.
- Arithmetic:
  - prod = signed(wave_i) * signed({1'b0, env}), 21-bit.
  - sample_o = prod >>> 4, truncated to 16 bits. No overflow is possible because env <= 15.
  - env==0 gives sample_o=0.
- Back-to-back ticks (tick_i high on consecutive cycles) must be supported; the pipeline is fully registered per stage.
- busy_o = (state != IDLE), registered with the state.

Optional Feature:
- Macro: AUDIO_TONE_PHASE_RST_EN.
- Defined: every key_on_i (including retrigger) clears acc to 0, so the note starts at ramp 0.
- Undefined: acc is cleared only on entry to IDLE; a retrigger keeps the phase free-running.

Decomposition:
- Package audio_pkg:
  - env_state_t enum {IDLE, ATTACK, SUSTAIN, RELEASE}.
  - Constants RAMP_W=6, SAMPLE_W=16, ENV_W=4.
- Sub-module audio_env_gen:
  - Contains the envelope FSM and step counter.
  - Inputs: tick, key_on, key_off, vol.
  - Outputs: env, state.
- The accumulator and scaling pipeline stay in the top module.

Test Plan:
- Reset held, then released, no key -> ramp_o=0, sample_o=0, busy_o=0. Each tick still yields sample_vld_o with 0 at T+2.
- freq_i=0x10000, vol_i=15, key_on, square table model (ramp<32: 0xE000, else 0x1FFF) -> ramp_o increments by 1 per tick and wraps 63->0. After sustain, samples alternate 0xE200 (32 ticks) and 0x1DFF (32 ticks).
- vol_i=4, ATTACK_TICKS=4 -> env reaches 4 after 16 ticks and enters SUSTAIN. Scaled low level = (-8192*4)>>>4 = 0xF800.
- key_off in SUSTAIN at env=15, RELEASE_TICKS=8 -> IDLE after 120 ticks, busy_o falls, acc=0, ramp_o=0.
- key_on and key_off in the same cycle during SUSTAIN -> RELEASE entered; no retrigger.
- Retrigger mid-note at ramp_o=20 -> with AUDIO_TONE_PHASE_RST_EN, ramp_o=0 on the next tick update; without it, ramp_o continues at 21.
- Assert reset during RELEASE -> all outputs 0 asynchronously; no sample_vld_o until the next tick after release.
